// File: rtl/decode_stage.sv
// RV32I/RV64I registered decode stage with a two-entry (main + skid) output buffer.
// Define DECODE_MEXT_EN to accept the M-extension REG_OP encodings (funct7 = 0000001).

`ifndef BRANCH_NONE
`define BRANCH_NONE 3'b010
`endif

module decode_stage #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instruction,
   input  logic [XLEN-1:0] in_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [4:0]      rs1,
   output logic [4:0]      rs2,
   output logic [4:0]      rd,
   output logic [XLEN-1:0] immediate,
   output logic            alu_use_rs2,
   output logic            alu_use_pc,
   output logic [4:0]      alu_op,
   output logic            reg_write,
   output logic            mem_write,
   output logic            mem_read,
   output logic            jump,
   output logic            illegal,
   output logic [2:0]      mem_op_length,
   output logic [2:0]      branch_type
);

`ifdef DECODE_MEXT_EN
   localparam bit MEXT_EN = 1'b1;
`else
   localparam bit MEXT_EN = 1'b0;
`endif

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
      logic [XLEN-1:0] imm;
      logic            useRs2;
      logic            usePc;
      logic [4:0]      aluOp;
      logic            regWrite;
      logic            memWrite;
      logic            memRead;
      logic            jump;
      logic            illegal;
      logic [2:0]      memLen;
      logic [2:0]      brType;
   } bundle_t;

   function automatic logic [XLEN-1:0] sext(input logic signed [31:0] v);
      return XLEN'(v);
   endfunction

   logic [6:0]         w_opcode;
   logic [2:0]         w_funct3;
   logic [6:0]         w_funct7;
   logic signed [31:0] w_immI;
   logic signed [31:0] w_immS;
   logic signed [31:0] w_immB;
   logic signed [31:0] w_immU;
   logic signed [31:0] w_immJ;
   logic [XLEN-1:0]    w_shamt;
   bundle_t            w_dec;
   logic               w_accept;
   logic               w_mainFree;

   bundle_t            r_main;
   bundle_t            r_skid;
   logic               r_mainValid;
   logic               r_skidValid;
   logic               r_inReady;

   assign w_opcode = in_instruction[6:0];
   assign w_funct3 = in_instruction[14:12];
   assign w_funct7 = in_instruction[31:25];
   assign w_immI   = {{20{in_instruction[31]}}, in_instruction[31:20]};
   assign w_immS   = {{20{in_instruction[31]}}, in_instruction[31:25], in_instruction[11:7]};
   assign w_immB   = {{19{in_instruction[31]}}, in_instruction[31], in_instruction[7],
                      in_instruction[30:25], in_instruction[11:8], 1'b0};
   assign w_immU   = {in_instruction[31:12], 12'b0};
   assign w_immJ   = {{11{in_instruction[31]}}, in_instruction[31], in_instruction[19:12],
                      in_instruction[20], in_instruction[30:21], 1'b0};
   // RV64 shift amounts use one more bit; on RV32 that bit must be zero.
   assign w_shamt  = (XLEN == 64) ? XLEN'(in_instruction[25:20]) : XLEN'(in_instruction[24:20]);

   always_comb begin
      w_dec        = '0;
      w_dec.pc     = in_pc;
      w_dec.rs1    = in_instruction[19:15];
      w_dec.rs2    = in_instruction[24:20];
      w_dec.rd     = in_instruction[11:7];
      w_dec.brType = `BRANCH_NONE;
      case (w_opcode)
         OP_LOAD: begin
            w_dec.imm      = sext(w_immI);
            w_dec.memRead  = 1'b1;
            w_dec.regWrite = 1'b1;
            w_dec.memLen   = w_funct3;
         end
         OP_STORE: begin
            w_dec.imm      = sext(w_immS);
            w_dec.memWrite = 1'b1;
            w_dec.memLen   = w_funct3;
         end
         OP_BRANCH: begin
            w_dec.imm    = sext(w_immB);
            w_dec.useRs2 = 1'b1;
            w_dec.aluOp  = {1'b0, in_instruction[30], w_funct3};
            w_dec.brType = w_funct3;
         end
         OP_JAL: begin
            w_dec.imm      = sext(w_immJ);
            w_dec.jump     = 1'b1;
            w_dec.usePc    = 1'b1;
            w_dec.regWrite = 1'b1;
         end
         OP_JALR: begin
            w_dec.imm      = sext(w_immI);
            w_dec.jump     = 1'b1;
            w_dec.regWrite = 1'b1;
         end
         OP_LUI: begin
            w_dec.imm      = sext(w_immU);
            w_dec.rs1      = 5'd0;
            w_dec.regWrite = 1'b1;
         end
         OP_AUIPC: begin
            w_dec.imm      = sext(w_immU);
            w_dec.usePc    = 1'b1;
            w_dec.regWrite = 1'b1;
         end
         OP_IMM: begin
            w_dec.regWrite = 1'b1;
            if (w_funct3[1:0] == 2'b01) begin
               w_dec.imm     = w_shamt;
               w_dec.aluOp   = {1'b0, (w_funct3 == 3'b101) ? in_instruction[30] : 1'b0, w_funct3};
               w_dec.illegal = (XLEN == 32) && in_instruction[25];
            end else begin
               w_dec.imm   = sext(w_immI);
               w_dec.aluOp = {2'b00, w_funct3};
            end
         end
         OP_REG: begin
            w_dec.useRs2   = 1'b1;
            w_dec.regWrite = 1'b1;
            if (w_funct7 == 7'b0000000) begin
               w_dec.aluOp = {2'b00, w_funct3};
            end else if (w_funct7 == 7'b0100000 && (w_funct3 == 3'b000 || w_funct3 == 3'b101)) begin
               w_dec.aluOp = {2'b01, w_funct3};
            end else if (MEXT_EN && w_funct7 == 7'b0000001) begin
               w_dec.aluOp = {2'b10, w_funct3};
            end else begin
               w_dec.illegal = 1'b1;
            end
         end
         default: w_dec.illegal = 1'b1;
      endcase
      // An illegal instruction must never cause architectural side effects downstream.
      if (w_dec.illegal) begin
         w_dec.regWrite = 1'b0;
         w_dec.memRead  = 1'b0;
         w_dec.memWrite = 1'b0;
         w_dec.jump     = 1'b0;
         w_dec.brType   = `BRANCH_NONE;
      end
   end

   assign w_accept   = in_valid && r_inReady;
   assign w_mainFree = !r_mainValid || out_ready;

   // Main feeds execute; skid catches the one instruction that arrives while main is stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_main             <= '0;
         r_main.brType      <= `BRANCH_NONE;
         r_skid             <= '0;
         r_skid.brType      <= `BRANCH_NONE;
         r_mainValid        <= 1'b0;
         r_skidValid        <= 1'b0;
         r_inReady          <= 1'b1;
      end else if (flush) begin
         r_mainValid        <= 1'b0;
         r_skidValid        <= 1'b0;
         r_inReady          <= 1'b1;
      end else if (w_mainFree) begin
         if (r_skidValid) begin
            r_main          <= r_skid;
            r_mainValid     <= 1'b1;
            r_skidValid     <= 1'b0;
            r_inReady       <= 1'b1;
         end else begin
            r_mainValid     <= w_accept;
            if (w_accept) begin
               r_main       <= w_dec;
            end
         end
      end else if (w_accept) begin
         r_skid             <= w_dec;
         r_skidValid        <= 1'b1;
         r_inReady          <= 1'b0;
      end
   end

   assign in_ready      = r_inReady;
   assign out_valid     = r_mainValid;
   assign out_pc        = r_main.pc;
   assign rs1           = r_main.rs1;
   assign rs2           = r_main.rs2;
   assign rd            = r_main.rd;
   assign immediate     = r_main.imm;
   assign alu_use_rs2   = r_main.useRs2;
   assign alu_use_pc    = r_main.usePc;
   assign alu_op        = r_main.aluOp;
   assign reg_write     = r_main.regWrite;
   assign mem_write     = r_main.memWrite;
   assign mem_read      = r_main.memRead;
   assign jump          = r_main.jump;
   assign illegal       = r_main.illegal;
   assign mem_op_length = r_main.memLen;
   assign branch_type   = r_main.brType;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage (XLEN=32): directed scenarios plus a randomized
// stream scored against a depth-2 FIFO model with an arithmetic instruction decoder.

module tb_decode_stage;

   localparam logic [2:0] BR_NONE = 3'b010;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic [31:0] in_instruction = '0;
   logic [31:0] in_pc = '0;
   logic        in_ready, out_valid;
   logic [31:0] out_pc, immediate;
   logic [4:0]  rs1, rs2, rd, alu_op;
   logic        alu_use_rs2, alu_use_pc, reg_write, mem_write, mem_read, jump, illegal;
   logic [2:0]  mem_op_length, branch_type;

   int nChecks = 0;
   int nPass = 0;

   typedef struct packed {
      logic [31:0] pc;
      logic [4:0]  rs1, rs2, rd;
      logic [31:0] imm;
      logic        useRs2, usePc;
      logic [4:0]  aluOp;
      logic        regWrite, memWrite, memRead, jump, illegal;
      logic [2:0]  memLen, brType;
   } dec_t;

   decode_stage #(.XLEN(32)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_instruction(in_instruction), .in_pc(in_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
      .rs1(rs1), .rs2(rs2), .rd(rd), .immediate(immediate),
      .alu_use_rs2(alu_use_rs2), .alu_use_pc(alu_use_pc), .alu_op(alu_op),
      .reg_write(reg_write), .mem_write(mem_write), .mem_read(mem_read),
      .jump(jump), .illegal(illegal), .mem_op_length(mem_op_length),
      .branch_type(branch_type)
   );

   always #5 clk = ~clk;

   function automatic dec_t observed();
      dec_t d;
      d = {out_pc, rs1, rs2, rd, immediate, alu_use_rs2, alu_use_pc, alu_op,
           reg_write, mem_write, mem_read, jump, illegal, mem_op_length, branch_type};
      return d;
   endfunction

   function automatic dec_t resetBundle();
      dec_t d = '0;
      d.brType = BR_NONE;
      return d;
   endfunction

   // Fields that carry no meaning for an illegal instruction are cleared before comparing.
   function automatic dec_t careOnly(input dec_t d);
      dec_t r = d;
      if (d.illegal) begin
         r.rs1 = '0; r.rs2 = '0; r.rd = '0; r.imm = '0;
         r.useRs2 = 1'b0; r.usePc = 1'b0; r.aluOp = '0; r.memLen = '0;
      end
      return r;
   endfunction

   function automatic dec_t refDecode(input logic [31:0] ins, input logic [31:0] pc);
      dec_t d = '0;
      int v;
      bit mext;
      logic [2:0] f3 = ins[14:12];
      logic [6:0] f7 = ins[31:25];
`ifdef DECODE_MEXT_EN
      mext = 1'b1;
`else
      mext = 1'b0;
`endif
      d.pc = pc; d.rs1 = ins[19:15]; d.rs2 = ins[24:20]; d.rd = ins[11:7];
      d.brType = BR_NONE;
      case (ins[6:0])
         7'h03, 7'h67: begin
            v = int'(ins[31:20]);
            if (v >= 2048) v -= 4096;
            d.imm = v;
            d.regWrite = 1'b1;
            if (ins[6:0] == 7'h03) begin d.memRead = 1'b1; d.memLen = f3; end
            else d.jump = 1'b1;
         end
         7'h23: begin
            v = int'(f7) * 32 + int'(ins[11:7]);
            if (v >= 2048) v -= 4096;
            d.imm = v; d.memWrite = 1'b1; d.memLen = f3;
         end
         7'h63: begin
            v = int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2 - (ins[31] ? 4096 : 0);
            d.imm = v; d.useRs2 = 1'b1; d.brType = f3; d.aluOp = {1'b0, ins[30], f3};
         end
         7'h6F: begin
            v = int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2 - (ins[31] ? 1048576 : 0);
            d.imm = v; d.jump = 1'b1; d.usePc = 1'b1; d.regWrite = 1'b1;
         end
         7'h37, 7'h17: begin
            d.imm = {ins[31:12], 12'h000}; d.regWrite = 1'b1;
            if (ins[6:0] == 7'h37) d.rs1 = 5'd0; else d.usePc = 1'b1;
         end
         7'h13: begin
            d.regWrite = 1'b1;
            if (f3 == 3'd1 || f3 == 3'd5) begin
               d.imm = 32'(ins[24:20]);
               d.aluOp = (f3 == 3'd5) ? {1'b0, ins[30], f3} : {2'b00, f3};
               d.illegal = ins[25];
            end else begin
               v = int'(ins[31:20]);
               if (v >= 2048) v -= 4096;
               d.imm = v; d.aluOp = {2'b00, f3};
            end
         end
         7'h33: begin
            d.regWrite = 1'b1; d.useRs2 = 1'b1;
            if (f7 == 7'h00) d.aluOp = {2'b00, f3};
            else if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) d.aluOp = {2'b01, f3};
            else if (f7 == 7'h01 && mext) d.aluOp = {2'b10, f3};
            else d.illegal = 1'b1;
         end
         default: d.illegal = 1'b1;
      endcase
      if (d.illegal) begin
         d.regWrite = 1'b0; d.memRead = 1'b0; d.memWrite = 1'b0; d.jump = 1'b0; d.brType = BR_NONE;
      end
      return careOnly(d);
   endfunction

   function automatic logic [31:0] randInstr();
      logic [6:0] ops [9] = '{7'h03, 7'h23, 7'h63, 7'h67, 7'h6F, 7'h13, 7'h33, 7'h37, 7'h17};
      logic [31:0] ins = $urandom;
      int k = $urandom_range(0, 9);
      if (k < 9) ins[6:0] = ops[k];
      if (ins[6:0] == 7'h33) begin
         case ($urandom_range(0, 3))
            0: ins[31:25] = 7'h00;
            1: ins[31:25] = 7'h20;
            2: ins[31:25] = 7'h01;
            default: ;
         endcase
      end
      if (ins[6:0] == 7'h13 && ins[13:12] == 2'b01) begin
         ins[31:26] = ($urandom_range(0, 1) == 1) ? 6'b010000 : 6'b000000;
         ins[25] = ($urandom_range(0, 3) == 0);
      end
      return ins;
   endfunction

   task automatic sendOne(input logic [31:0] ins, input logic [31:0] pc);
      in_valid = 1'b1; in_instruction = ins; in_pc = pc;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      out_ready = 1'b1; in_valid = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      nChecks++;
      if (observed() !== resetBundle()) $display("[TB] FAIL reset_fields got %h expected %h", observed(), resetBundle());
      else nPass++;
      nChecks++;
      if ({out_valid, in_ready} !== 2'b01) $display("[TB] FAIL reset_handshake got %b expected 01", {out_valid, in_ready});
      else nPass++;
      @(negedge clk) rst_n = 1'b1;
   endtask

   task automatic test_addi();
      out_ready = 1'b1;
      sendOne(32'h00500093, 32'h100);
      nChecks++;
      if (out_valid !== 1'b1) $display("[TB] FAIL addi_valid got %b expected 1", out_valid);
      else nPass++;
      nChecks++;
      if ({rd, rs1, immediate, alu_op, reg_write, illegal} !== {5'd1, 5'd0, 32'd5, 5'd0, 1'b1, 1'b0})
         $display("[TB] FAIL addi_fields got rd=%0d rs1=%0d imm=%h op=%h rw=%b ill=%b expected rd=1 rs1=0 imm=5 op=0 rw=1 ill=0",
                  rd, rs1, immediate, alu_op, reg_write, illegal);
      else nPass++;
      nChecks++;
      if (careOnly(observed()) !== refDecode(32'h00500093, 32'h100))
         $display("[TB] FAIL addi_model got %h expected %h", careOnly(observed()), refDecode(32'h00500093, 32'h100));
      else nPass++;
   endtask

   task automatic test_store();
      sendOne(32'hFE20AE23, 32'h104);
      nChecks++;
      if ({immediate, mem_write, reg_write, mem_op_length} !== {32'hFFFFFFFC, 1'b1, 1'b0, 3'd2})
         $display("[TB] FAIL sw_fields got imm=%h mw=%b rw=%b len=%0d expected imm=fffffffc mw=1 rw=0 len=2",
                  immediate, mem_write, reg_write, mem_op_length);
      else nPass++;
      nChecks++;
      if (careOnly(observed()) !== refDecode(32'hFE20AE23, 32'h104))
         $display("[TB] FAIL sw_model got %h expected %h", careOnly(observed()), refDecode(32'hFE20AE23, 32'h104));
      else nPass++;
   endtask

   task automatic test_stall();
      logic [31:0] ins [3];
      dec_t exp [3];
      for (int i = 0; i < 3; i++) begin
         ins[i] = randInstr();
         exp[i] = refDecode(ins[i], 32'h200 + 32'(4 * i));
      end
      drain();
      nChecks++;
      if (out_valid !== 1'b0) $display("[TB] FAIL stall_empty got %b expected 0", out_valid);
      else nPass++;
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_instruction = ins[i]; in_pc = 32'h200 + 32'(4 * i);
         @(posedge clk); #1;
         nChecks++;
         if (in_ready !== (i == 0)) $display("[TB] FAIL stall_ready_%0d got %b expected %b", i, in_ready, i == 0);
         else nPass++;
         nChecks++;
         if (careOnly(observed()) !== exp[0] || out_valid !== 1'b1)
            $display("[TB] FAIL stall_hold_%0d got %h expected %h", i, careOnly(observed()), exp[0]);
         else nPass++;
      end
      out_ready = 1'b1;
      for (int i = 1; i < 3; i++) begin
         @(posedge clk); #1;
         nChecks++;
         if (careOnly(observed()) !== exp[i] || out_valid !== 1'b1)
            $display("[TB] FAIL stall_order_%0d got %h expected %h", i, careOnly(observed()), exp[i]);
         else nPass++;
         nChecks++;
         if (in_ready !== 1'b1) $display("[TB] FAIL stall_reopen_%0d got %b expected 1", i, in_ready);
         else nPass++;
      end
      in_valid = 1'b0;
      @(posedge clk); #1;
      nChecks++;
      if (out_valid !== 1'b0) $display("[TB] FAIL stall_nodup got %b expected 0", out_valid);
      else nPass++;
   endtask

   task automatic test_jal_illegal();
      out_ready = 1'b1;
      sendOne(32'h001000EF, 32'h300);
      nChecks++;
      if ({jump, alu_use_pc, immediate, rd, reg_write} !== {1'b1, 1'b1, 32'h800, 5'd1, 1'b1})
         $display("[TB] FAIL jal_fields got j=%b pc=%b imm=%h rd=%0d rw=%b expected j=1 pc=1 imm=800 rd=1 rw=1",
                  jump, alu_use_pc, immediate, rd, reg_write);
      else nPass++;
      nChecks++;
      if (careOnly(observed()) !== refDecode(32'h001000EF, 32'h300))
         $display("[TB] FAIL jal_model got %h expected %h", careOnly(observed()), refDecode(32'h001000EF, 32'h300));
      else nPass++;
      sendOne(32'h00000000, 32'h304);
      nChecks++;
      if ({illegal, reg_write, mem_read, mem_write, jump, branch_type} !== {1'b1, 4'b0000, BR_NONE})
         $display("[TB] FAIL zero_illegal got ill=%b rw=%b mr=%b mw=%b j=%b br=%b expected ill=1 rw=0 mr=0 mw=0 j=0 br=010",
                  illegal, reg_write, mem_read, mem_write, jump, branch_type);
      else nPass++;
      nChecks++;
      if (out_pc !== 32'h304) $display("[TB] FAIL zero_pc got %h expected 304", out_pc);
      else nPass++;
   endtask

   task automatic test_flush();
      drain();
      out_ready = 1'b0;
      sendOne(32'h00100113, 32'h500);
      sendOne(32'h00200193, 32'h504);
      nChecks++;
      if (in_ready !== 1'b0) $display("[TB] FAIL flush_skidfull got %b expected 0", in_ready);
      else nPass++;
      in_valid = 1'b1; in_instruction = 32'h00300213; in_pc = 32'h508; flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      nChecks++;
      if ({out_valid, in_ready} !== 2'b01) $display("[TB] FAIL flush_clear got %b expected 01", {out_valid, in_ready});
      else nPass++;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         nChecks++;
         if (out_valid !== 1'b0) $display("[TB] FAIL flush_leak_%0d got valid=%b pc=%h expected valid=0", i, out_valid, out_pc);
         else nPass++;
      end
   endtask

   task automatic test_reset_midstall();
      drain();
      out_ready = 1'b0;
      sendOne(32'h00A00093, 32'h600);
      sendOne(32'hFE20AE23, 32'h604);
      #2 rst_n = 1'b0;
      #1;
      nChecks++;
      if (observed() !== resetBundle()) $display("[TB] FAIL rstmid_fields got %h expected %h", observed(), resetBundle());
      else nPass++;
      nChecks++;
      if ({out_valid, in_ready} !== 2'b01) $display("[TB] FAIL rstmid_handshake got %b expected 01", {out_valid, in_ready});
      else nPass++;
      @(negedge clk) rst_n = 1'b1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      nChecks++;
      if ({out_valid, in_ready} !== 2'b01) $display("[TB] FAIL rstmid_after got %b expected 01", {out_valid, in_ready});
      else nPass++;
   endtask

   task automatic test_mext();
      drain();
      sendOne(32'h022081B3, 32'h700);
`ifdef DECODE_MEXT_EN
      nChecks++;
      if ({alu_op, illegal, reg_write, alu_use_rs2} !== {5'h10, 1'b0, 1'b1, 1'b1})
         $display("[TB] FAIL mul_fields got op=%h ill=%b rw=%b rs2=%b expected op=10 ill=0 rw=1 rs2=1",
                  alu_op, illegal, reg_write, alu_use_rs2);
      else nPass++;
`else
      nChecks++;
      if ({illegal, reg_write} !== 2'b10)
         $display("[TB] FAIL mul_fields got ill=%b rw=%b expected ill=1 rw=0", illegal, reg_write);
      else nPass++;
`endif
      nChecks++;
      if (careOnly(observed()) !== refDecode(32'h022081B3, 32'h700))
         $display("[TB] FAIL mul_model got %h expected %h", careOnly(observed()), refDecode(32'h022081B3, 32'h700));
      else nPass++;
   endtask

   task automatic test_back_to_back();
      dec_t q [$];
      bit doPop, doPush;
      drain();
      for (int i = 0; i < 606; i++) begin
         if (i < 600) begin
            in_valid = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            flush = ($urandom_range(0, 49) == 0);
         end else begin
            in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
         end
         in_instruction = randInstr();
         in_pc = $urandom & 32'hFFFF_FFFC;
         @(negedge clk);
         nChecks++;
         if (out_valid !== (q.size() > 0) || in_ready !== (q.size() < 2))
            $display("[TB] FAIL b2b_hs_%0d got valid=%b ready=%b expected valid=%b ready=%b",
                     i, out_valid, in_ready, q.size() > 0, q.size() < 2);
         else nPass++;
         if (q.size() > 0) begin
            nChecks++;
            if (careOnly(observed()) !== q[0])
               $display("[TB] FAIL b2b_item_%0d got %h expected %h", i, careOnly(observed()), q[0]);
            else nPass++;
         end
         if (flush) begin
            q.delete();
         end else begin
            doPop = (q.size() > 0) && out_ready;
            doPush = in_valid && (q.size() < 2);
            if (doPop) void'(q.pop_front());
            if (doPush) q.push_back(refDecode(in_instruction, in_pc));
         end
         @(posedge clk); #1;
      end
      nChecks++;
      if (out_valid !== 1'b0) $display("[TB] FAIL b2b_drained got %b expected 0", out_valid);
      else nPass++;
   endtask

   initial begin
      $display("[TB] decode_stage bench start");
      test_reset();
      test_addi();
      test_store();
      test_stall();
      test_jal_illegal();
      test_flush();
      test_reset_midstall();
      test_mext();
      test_back_to_back();
      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered, parametrised RV32I/RV64I instruction decode stage that sits between fetch and execute. It accepts one instruction per cycle over a valid/ready handshake and presents fully decoded control fields one cycle later. A two-entry skid buffer lets it absorb execute-side stalls without dropping instructions. Beyond the plain combinational decoder it adds U/J-type and JALR decode, illegal-instruction detection, pipeline flush and an optional M-extension.

## Interface
- XLEN, 32: datapath width, 32 or 64; sets immediate/pc width and shamt width.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous pipeline flush.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  stage can accept (registered).
- in_instruction  in  32  raw instruction.
- in_pc  in  XLEN  instruction address.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  execute accepts bundle.
- out_pc  out  XLEN  pc of presented instruction.
- rs1, rs2, rd  out  5 each  register indices: instr[19:15], [24:20], [11:7].
- immediate  out  XLEN  sign-extended immediate.
- alu_use_rs2, alu_use_pc  out  1 each  ALU operand B = rs2 / operand A = pc.
- alu_op  out  5  {m_ext, instr[30] or 0, funct3}.
- reg_write, mem_write, mem_read, jump, illegal  out  1 each.
- mem_op_length  out  3  funct3 for loads/stores.
- branch_type  out  3  funct3 for BRANCH_OP, else `BRANCH_NONE.

## Operation
- Input accepted when in_valid && in_ready. Decode is combinational on in_instruction; the result is captured into the output register (main) or the skid register.
- Main empty or (out_valid && out_ready): the accepted bundle loads main. Otherwise it loads skid. When main drains and skid is full, skid moves to main.
- in_ready is registered; it equals !skid_full.
- Immediates:
  - I-type: instr[31:20], sign-extended.
  - S-type: {[31:25],[11:7]}.
  - B-type: {[31],[7],[30:25],[11:8],0}.
  - U-type (LUI/AUIPC): {[31:12],12'b0}.
  - J-type (JAL): {[31],[19:12],[20],[30:21],0}.
  - All are sign-extended to XLEN.
  - SRLI/SRAI/SLLI shamt is zero-extended: instr[24:20] for XLEN=32, instr[25:20] for XLEN=64.
- alu_op:
  - Load/store/JAL/JALR/AUIPC: ADD (0).
  - LUI: ADD with rs1 forced to 0.
  - IMM_OP except funct3=101: {0,0,funct3}.
  - Otherwise: {0,instr[30],funct3}.
- alu_use_pc=1 for AUIPC and JAL. jump=1 for JAL and JALR. reg_write=1 for LOAD, REG, IMM, LUI, AUIPC, JAL, JALR.
- illegal=1 when any of the following holds:
  - instr[1:0]≠11 or the opcode is unrecognised.
  - REG_OP funct7 is not in {0000000, 0100000 (ADD/SRA/SUB/SRL only)}, with the M-ext exception below.
  - XLEN=32 and a shift-immediate has instr[25]=1.
- When illegal=1: reg_write, mem_read, mem_write and jump are 0, and branch_type=`BRANCH_NONE. Other fields are don't-care.

## Timing
- Latency is 1 cycle: an instruction accepted at edge N gives out_valid high after edge N.
- Throughput is 1 per cycle while out_ready is high.
- Outputs hold stable while out_valid && !out_ready.
- Stall: at most one extra instruction is accepted. On the edge where skid fills, in_ready drops; it rises the cycle after skid drains.
- Order is preserved: main before skid.
- Flush has priority over everything. At the next edge, main and skid are invalidated, in_ready=1, and any same-cycle input is discarded.
- Reset (asynchronous, any time, including mid-stall): out_valid=0, skid empty, in_ready=1, every data output 0, branch_type=`BRANCH_NONE.

## Configuration
- DECODE_MEXT_EN defined: REG_OP with funct7=0000001 is legal. alu_op={1,0,funct3} (MUL..REMU), reg_write=1, alu_use_rs2=1.
- DECODE_MEXT_EN undefined: the same encoding is flagged illegal. alu_op[4] is tied to 0.

## Test plan
- Reset, then addi x1,x0,5 (0x00500093) with out_ready=1 -> next cycle: out_valid=1, rd=1, rs1=0, immediate=5, alu_op=0, reg_write=1, illegal=0.
- sw x2,-4(x1) (0xFE20AE23) -> immediate=0xFFFFFFFC, mem_write=1, reg_write=0, mem_op_length=2.
- Hold out_ready=0 and stream 3 instructions -> the first two are accepted and in_ready=0 on the third. Release out_ready -> outputs appear in order with no loss or duplication.
- jal x1,+2048 (0x001000EF) -> jump=1, alu_use_pc=1, immediate=0x800. Then 0x00000000 -> illegal=1, reg_write=0.
- Assert flush with skid full and in_valid=1 -> next cycle out_valid=0, in_ready=1, no flushed pc emerges later. Repeat with rst_n pulsed mid-stall -> all outputs 0.
- mul x3,x1,x2 (0x022081B3) -> with DECODE_MEXT_EN: alu_op=0x10, illegal=0. Without it: illegal=1.
